// File: rtl/dram_port_if.sv
// Avalon-MM master command/response bundle between dram_port and the memory slave.
interface dram_port_if;
  logic [24:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/dram_port.sv
// Change-triggered single-outstanding Avalon-MM port: a new {addr, we, wdata} launches one read or write.
// Optional read timeout (16'hDEAD + sticky err) enabled by macro DRAM_PORT_TIMEOUT_EN.
module dram_port (
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] dram_addr,
  input  logic        dram_write_en,
  input  logic [15:0] dram_write_data,
  output logic [15:0] dram_read_data,
  output logic        busy,
  dram_port_if.master avm
`ifdef DRAM_PORT_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t      state_q, state_d;
  logic        op_vld_q, op_vld_d;
  logic [24:0] op_addr_q, op_addr_d;
  logic        op_we_q, op_we_d;
  logic [15:0] op_wdata_q, op_wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        new_op;

`ifdef DRAM_PORT_TIMEOUT_EN
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  // last_op doubles as the command register, so the bus sees exactly what was compared
  assign new_op = !op_vld_q || (dram_addr != op_addr_q) ||
                  (dram_write_en != op_we_q) || (dram_write_data != op_wdata_q);

  always_comb begin
    state_d      = state_q;
    op_vld_d     = op_vld_q;
    op_addr_d    = op_addr_q;
    op_we_d      = op_we_q;
    op_wdata_d   = op_wdata_q;
    rdata_d      = rdata_q;
    avm.avm_read  = 1'b0;
    avm.avm_write = 1'b0;
`ifdef DRAM_PORT_TIMEOUT_EN
    cnt_d        = 4'd0;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (new_op) begin
          op_vld_d   = 1'b1;
          op_addr_d  = dram_addr;
          op_we_d    = dram_write_en;
          op_wdata_d = dram_write_data;
          state_d    = dram_write_en ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ: begin
        avm.avm_read = 1'b1;
        if (!avm.avm_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (avm.avm_readdatavalid) begin
          rdata_d = avm.avm_readdata;
          state_d = IDLE;
        end
`ifdef DRAM_PORT_TIMEOUT_EN
        // 15th cycle without a response gives up
        else if (cnt_q == 4'd14) begin
          rdata_d = 16'hDEAD;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      WR_REQ: begin
        avm.avm_write = 1'b1;
        if (!avm.avm_waitrequest) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_vld_q   <= 1'b0;
      op_addr_q  <= 25'd0;
      op_we_q    <= 1'b0;
      op_wdata_q <= 16'd0;
      rdata_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      op_vld_q   <= op_vld_d;
      op_addr_q  <= op_addr_d;
      op_we_q    <= op_we_d;
      op_wdata_q <= op_wdata_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef DRAM_PORT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  assign avm.avm_address   = op_addr_q;
  assign avm.avm_writedata = op_wdata_q;
  assign dram_read_data    = rdata_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_dram_port.sv
// Directed bench for dram_port: vector table for the basic read/write flow, hand sequences for corner cases.
module tb_dram_port;
  logic        clk;
  logic        rst;
  logic [24:0] dram_addr;
  logic        dram_write_en;
  logic [15:0] dram_write_data;
  logic [15:0] dram_read_data;
  logic        busy;
`ifdef DRAM_PORT_TIMEOUT_EN
  logic        err;
`endif

  dram_port_if avm ();

  dram_port dut (
    .clk            (clk),
    .rst            (rst),
    .dram_addr      (dram_addr),
    .dram_write_en  (dram_write_en),
    .dram_write_data(dram_write_data),
    .dram_read_data (dram_read_data),
    .busy           (busy),
    .avm            (avm.master)
`ifdef DRAM_PORT_TIMEOUT_EN
    ,
    .err            (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [24:0] addr;
    logic        we;
    logic [15:0] wd;
    logic        wr;
    logic        rdv;
    logic [15:0] rd;
    logic        e_read;
    logic        e_write;
    logic        e_busy;
    logic [15:0] e_rdata;
    logic [24:0] e_addr;
    logic [15:0] e_wdata;
  } vec_t;

  vec_t        vt [12];
  int          checks = 0;
  int          errors = 0;
  logic        auto_en = 1'b0;
  logic [24:0] rd_log [$];

  function automatic logic [15:0] slave_data(input logic [24:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock: log accepted reads, advance, optionally play a slave answering one cycle after accept
  task automatic step();
    logic        acc;
    logic [24:0] a;
    acc = avm.avm_read && !avm.avm_waitrequest;
    a   = avm.avm_address;
    if (acc) rd_log.push_back(a);
    @(posedge clk);
    #1;
    if (auto_en) begin
      avm.avm_readdatavalid = acc;
      avm.avm_readdata      = acc ? slave_data(a) : 16'h0000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           addr     we  wd       wr  rdv rd       rd wr by rdata    e_addr   e_wdata
    vt[0]  = '{25'h10, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 25'h10, 16'h0000};
    vt[1]  = '{25'h10, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 25'h10, 16'h0000};
    vt[2]  = '{25'h10, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h1234, 25'h10, 16'h0000};
    vt[3]  = '{25'h10, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 25'h10, 16'h0000};
    vt[4]  = '{25'h20, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 25'h20, 16'hBEEF};
    vt[5]  = '{25'h20, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 25'h20, 16'hBEEF};
    vt[6]  = '{25'h20, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 25'h20, 16'hBEEF};
    vt[7]  = '{25'h20, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 25'h20, 16'hBEEF};
    vt[8]  = '{25'h20, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 25'h20, 16'hBEEF};
    vt[9]  = '{25'h20, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 25'h20, 16'hBEEF};
    vt[10] = '{25'h20, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 25'h20, 16'hBEEF};
    vt[11] = '{25'h20, 1'b1, 16'hBEEF, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 16'h1234, 25'h20, 16'hBEEF};

    rst                   = 1'b0;
    dram_addr             = 25'h10;
    dram_write_en         = 1'b0;
    dram_write_data       = 16'h0000;
    avm.avm_waitrequest   = 1'b0;
    avm.avm_readdatavalid = 1'b0;
    avm.avm_readdata      = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {avm.avm_read, avm.avm_write, busy, dram_read_data, avm.avm_address, avm.avm_writedata},
          {1'b0, 1'b0, 1'b0, 16'h0000, 25'h0, 16'h0000});
`ifdef DRAM_PORT_TIMEOUT_EN
    check("reset_err", {63'd0, err}, 64'd0);
`endif
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      dram_addr             = vt[i].addr;
      dram_write_en         = vt[i].we;
      dram_write_data       = vt[i].wd;
      avm.avm_waitrequest   = vt[i].wr;
      avm.avm_readdatavalid = vt[i].rdv;
      avm.avm_readdata      = vt[i].rd;
      step();
      check($sformatf("vec%0d", i),
            {avm.avm_read, avm.avm_write, busy, dram_read_data, avm.avm_address, avm.avm_writedata},
            {vt[i].e_read, vt[i].e_write, vt[i].e_busy, vt[i].e_rdata, vt[i].e_addr, vt[i].e_wdata});
    end
    check("table_read_count", 64'(rd_log.size()), 64'd1);

    // steady inputs after a completed read must issue exactly one read
    avm.avm_waitrequest   = 1'b0;
    avm.avm_readdatavalid = 1'b0;
    auto_en               = 1'b1;
    rd_log.delete();
    dram_addr       = 25'h40;
    dram_write_en   = 1'b0;
    dram_write_data = 16'h0000;
    repeat (25) step();
    check("hold_read_count", 64'(rd_log.size()), 64'd1);
    if (rd_log.size() > 0) check("hold_read_addr", 64'(rd_log[0]), 64'h40);
    check("hold_rdata", {busy, dram_read_data}, {1'b0, 16'hA5E5});

    // input changes while busy: 0x2 is never issued
    rd_log.delete();
    dram_addr = 25'h1;
    step();
    dram_addr = 25'h2;
    step();
    dram_addr = 25'h3;
    step();
    repeat (6) step();
    check("busy_skip_count", 64'(rd_log.size()), 64'd2);
    if (rd_log.size() == 2) begin
      check("busy_skip_first", 64'(rd_log[0]), 64'h1);
      check("busy_skip_second", 64'(rd_log[1]), 64'h3);
    end
    check("busy_skip_rdata", {busy, dram_read_data}, {1'b0, 16'hA5A6});

    // reset during RD_WAIT, late response after release is dropped
    auto_en               = 1'b0;
    avm.avm_readdatavalid = 1'b0;
    rd_log.delete();
    dram_addr = 25'h77;
    step();
    step();
    check("pre_reset_state", {busy, avm.avm_read}, {1'b1, 1'b0});
    rst = 1'b0;
    #3;
    check("async_reset", {busy, avm.avm_read, dram_read_data}, {1'b0, 1'b0, 16'h0000});
    rst                   = 1'b1;
    avm.avm_readdatavalid = 1'b1;
    avm.avm_readdata      = 16'h5555;
    step();
    check("late_rdv_dropped", {dram_read_data, avm.avm_read, avm.avm_address},
          {16'h0000, 1'b1, 25'h77});
    avm.avm_readdatavalid = 1'b0;
    step();
    check("relaunch_wait", {busy, dram_read_data}, {1'b1, 16'h0000});
    avm.avm_readdatavalid = 1'b1;
    avm.avm_readdata      = 16'h0ABC;
    step();
    avm.avm_readdatavalid = 1'b0;
    check("relaunch_done", {busy, dram_read_data}, {1'b0, 16'h0ABC});

    // slave that never answers
    dram_addr = 25'h99;
    step();
    step();
`ifdef DRAM_PORT_TIMEOUT_EN
    repeat (14) step();
    check("timeout_not_yet", {busy, err, dram_read_data}, {1'b1, 1'b0, 16'h0ABC});
    step();
    check("timeout_fire", {busy, err, dram_read_data}, {1'b0, 1'b1, 16'hDEAD});
    repeat (3) step();
    check("timeout_err_sticky", {busy, err}, {1'b0, 1'b1});
`else
    repeat (30) step();
    check("no_timeout_busy", {busy, dram_read_data}, {1'b1, 16'h0ABC});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
